// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, fixed-latency memory between the instruction
//   fetch requester (IF) and the data-memory requester (DM). One access is
//   outstanding at a time; a new one may be accepted in the response cycle
//   of the previous one, giving one access per MEM_LATENCY cycles.
//   DM has priority. IF wins once after STARVE_LIMIT consecutive losses.
//
// Ports
//   clk, rst           clock (rising edge), async active-low reset
//   if_req/if_addr     IF read request          -> if_gnt, if_rvalid, if_rdata, if_stall
//   dm_req/dm_we/...   DM read/write request    -> dm_gnt, dm_rvalid, dm_rdata, dm_stall
//   mem_en/we/addr/wdata, mem_rdata   memory side (rdata MEM_LATENCY cycles after mem_en)
//
// Optional: define MEM_ARB_STATS_EN to add stat_if_cnt, stat_dm_cnt and
//   stat_conflict_cnt (IF grants, DM grants, accepts with both requesting).
module mem_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_if_cnt,
    output logic [31:0]       stat_dm_cnt,
    output logic [31:0]       stat_conflict_cnt
`endif
);

    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LAT  = CW'(MEM_LATENCY);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t        state, state_nxt;
    logic          owner, owner_nxt;        // 0 = IF, 1 = DM
    logic          is_write, is_write_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;

    logic resp, can_acc, if_win, dm_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            is_write   <= 1'b0;
            cnt        <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            is_write   <= is_write_nxt;
            cnt        <= cnt_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        is_write_nxt = is_write;
        cnt_nxt      = cnt;
        starve_nxt   = starve_cnt;

        resp = (state == S_WAIT) && (cnt == CW'(1));
        // Gate on rst so nothing is granted (or stalled) while reset is held.
        can_acc = rst && ((state == S_IDLE) || resp);
        if_win  = can_acc && if_req && (!dm_req || (starve_cnt == SLIM));
        dm_win  = can_acc && dm_req && !if_win;

        if (state == S_WAIT) cnt_nxt = cnt - CW'(1);
        if (resp) state_nxt = S_IDLE;

        if (if_win || dm_win) begin
            state_nxt    = S_WAIT;
            owner_nxt    = dm_win;
            is_write_nxt = dm_win && dm_we;
            cnt_nxt      = LAT;
        end

        if (if_win)
            starve_nxt = '0;
        else if (dm_win && if_req && (starve_cnt != SLIM))
            starve_nxt = starve_cnt + SW'(1);
    end

    assign if_gnt    = if_win;
    assign dm_gnt    = dm_win;
    assign mem_en    = if_win || dm_win;
    assign mem_we    = dm_win && dm_we;
    assign mem_addr  = dm_win ? dm_addr : (if_win ? if_addr : '0);
    assign mem_wdata = (dm_win && dm_we) ? dm_wdata : '0;

    assign if_rvalid = resp && !owner;
    assign dm_rvalid = resp && owner;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = (dm_rvalid && !is_write) ? mem_rdata : '0;

    assign if_stall = rst && ((if_req && !if_gnt) ||
                              (state == S_WAIT && !owner && !if_rvalid));
    assign dm_stall = rst && ((dm_req && !dm_gnt) ||
                              (state == S_WAIT && owner && !dm_rvalid));

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_if_cnt       <= '0;
            stat_dm_cnt       <= '0;
            stat_conflict_cnt <= '0;
        end else begin
            if (if_win) stat_if_cnt <= stat_if_cnt + 32'd1;
            if (dm_win) stat_dm_cnt <= stat_dm_cnt + 32'd1;
            if (mem_en && if_req && dm_req) stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch requester (IF) and the data-memory requester (DM, MEM stage).
- Arbitrates requests, sequences the fixed-latency memory access, returns read data to the winner and generates per-requester stall signals that freeze the pipeline registers.
- Sits between the pipeline stages and the memory array; replaces the separate program and data memory ports.

Parameters:
- ADDR_W, 10: word address width.
- DATA_W, 32: data width.
- MEM_LATENCY, 2: cycles from mem_en to valid mem_rdata; must be ≥1.
- STARVE_LIMIT, 4: consecutive IF arbitration losses before IF is forced to win once; must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- if_req  in  1  IF read request; held until if_gnt.
- if_addr  in  ADDR_W  IF word address; stable while if_req.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  IF read data valid.
- if_rdata  out  DATA_W  IF read data.
- if_stall  out  1  freeze IF stage.
- dm_req  in  1  DM request; held until dm_gnt.
- dm_we  in  1  DM write when 1, read when 0.
- dm_addr  in  ADDR_W  DM word address.
- dm_wdata  in  DATA_W  DM write data.
- dm_gnt  out  1  DM request accepted this cycle.
- dm_rvalid  out  1  DM read data valid, or write acknowledge.
- dm_rdata  out  DATA_W  DM read data; 0 on write acknowledge.
- dm_stall  out  1  freeze MEM stage and everything upstream.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; owner, wait counter and starve counter clear to 0.
  - All outputs are 0 during and after reset until the first request.
  - A transaction in flight when reset asserts is discarded; no rvalid is issued for it.
- States:
  - IDLE: no access outstanding.
  - WAIT: access outstanding. Holds owner (IF/DM), is_write, and a down-counter loaded with MEM_LATENCY.
- Accept rule:
  - A request can be accepted in IDLE, or in WAIT in the cycle the counter reaches 1 (the response cycle). This gives back-to-back throughput of one access per MEM_LATENCY cycles.
  - In the accept cycle: gnt is high combinationally for exactly one requester. mem_en=1, and mem_we/mem_addr/mem_wdata come from the winner (mem_we=0 for IF).
  - mem_en=0 in all other cycles. mem_addr/mem_wdata are 0 when mem_en=0.
- Arbitration when both request:
  - DM wins, unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - starve_cnt increments, saturating at STARVE_LIMIT, on each accept cycle where IF requested and lost.
  - starve_cnt clears whenever IF is granted.
  - A lone requester always wins.
- Response:
  - The owner's rvalid pulses one cycle, exactly MEM_LATENCY cycles after its gnt. rdata = mem_rdata that cycle; dm_rdata = 0 for a DM write.
  - rdata outputs are 0 when their rvalid is low.
  - After the response, go to IDLE if nothing is accepted in that cycle; otherwise reload the counter and stay in WAIT.
- Stalls (combinational):
  - if_stall = (if_req & ~if_gnt) | (owner==IF & WAIT & ~if_rvalid).
  - dm_stall is the same, using dm signals.
  - A requester granted with MEM_LATENCY ≥ 1 stays stalled until its rvalid cycle; it is not stalled in that cycle.
- Requester rule: req must not drop before gnt. A req drop before gnt is a protocol violation, and the arbiter's behaviour is then undefined.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined:
  - Adds outputs stat_if_cnt[31:0], stat_dm_cnt[31:0] and stat_conflict_cnt[31:0].
  - These count IF grants, DM grants, and accept cycles with both requests high.
  - Counters wrap modulo 2^32 and clear on reset.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan (defaults unless stated):
- Reset with if_req=1: all outputs 0. Release at cycle 0 → if_gnt at cycle 0 with mem_addr=if_addr=0x004. if_rvalid at cycle 2 with if_rdata=mem_rdata=0x00022020.
- DM write at addr 0x010, data 0xDEADBEEF → dm_gnt with mem_we=1, mem_wdata=0xDEADBEEF. dm_rvalid 2 cycles later with dm_rdata=0.
- Both requesting continuously → grant order DM,DM,DM,DM,IF,DM…. IF is granted on the 5th accept; there is one accept every 2 cycles.
- Back-to-back IF reads at 0x000, 0x001 → second if_gnt in the same cycle as the first if_rvalid. mem_en stays high on every other cycle with no idle gap.
- rst asserted one cycle after dm_gnt → dm_rvalid never pulses, state is IDLE, starve_cnt=0.
- MEM_ARB_STATS_EN with 6 conflicting accepts → stat_dm_cnt=5, stat_if_cnt=1, stat_conflict_cnt=6.
